// File: rtl/depth_test_writer.sv
// rtl/depth_test_writer.sv - depth-tested fragment writer with framebuffer clear sweep
// Two-stage read/compare/write pipeline with write forwarding, plus a drain-then-clear sequencer.
`timescale 1ns/1ps
module depth_test_writer #(
  parameter int                    DATAWIDTH   = 12,
  parameter int                    COLORWIDTH  = 4,
  parameter int                    ADDRWIDTH   = 16,
  parameter int                    FB_SIZE     = 102400,
  parameter logic [COLORWIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_frag_valid,
  input  logic [ADDRWIDTH-1:0]  i_frag_addr,
  input  logic [DATAWIDTH-1:0]  i_frag_depth,
  input  logic [COLORWIDTH-1:0] i_frag_color,
  output logic                  o_ready,
  input  logic                  i_clear,
  output logic                  o_clear_done,
  output logic [ADDRWIDTH-1:0]  o_zb_raddr,
  input  logic [DATAWIDTH-1:0]  i_zb_rdata,
  output logic [ADDRWIDTH-1:0]  o_zb_waddr,
  output logic [DATAWIDTH-1:0]  o_zb_wdata,
  output logic                  o_zb_we,
  output logic [ADDRWIDTH-1:0]  o_fb_waddr,
  output logic [COLORWIDTH-1:0] o_fb_wdata,
  output logic                  o_fb_we
);

  // The clear counter may need more bits than the address bus to reach FB_SIZE-1.
  localparam int CNTW = ($clog2(FB_SIZE) > ADDRWIDTH) ? $clog2(FB_SIZE) : ADDRWIDTH;
  localparam logic [CNTW-1:0] LAST_ADDR = CNTW'(FB_SIZE - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDRWIDTH-1:0]  s1_addr_q, s1_addr_d;
  logic [DATAWIDTH-1:0]  s1_depth_q, s1_depth_d;
  logic [COLORWIDTH-1:0] s1_color_q, s1_color_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  zb_we_q, zb_we_d;
  logic [ADDRWIDTH-1:0]  zb_waddr_q, zb_waddr_d;
  logic [DATAWIDTH-1:0]  zb_wdata_q, zb_wdata_d;
  logic [COLORWIDTH-1:0] fb_wdata_q, fb_wdata_d;
  logic                  prev_we_q, prev_we_d;
  logic [ADDRWIDTH-1:0]  prev_addr_q, prev_addr_d;
  logic [DATAWIDTH-1:0]  prev_wdata_q, prev_wdata_d;
  logic [CNTW-1:0]       clr_cnt_q, clr_cnt_d;

  logic                  accept;
  logic [DATAWIDTH-1:0]  stored_depth;

  assign o_ready      = ready_q && (state_q == IDLE);
  assign accept       = i_frag_valid && o_ready;
  assign o_zb_raddr   = i_frag_addr;
  assign o_clear_done = (state_q == DONE);
  assign o_zb_we      = zb_we_q;
  assign o_zb_waddr   = zb_waddr_q;
  assign o_zb_wdata   = zb_wdata_q;
  assign o_fb_we      = zb_we_q;
  assign o_fb_waddr   = zb_waddr_q;
  assign o_fb_wdata   = fb_wdata_q;

  // RAM data can be stale for the two writes not yet visible to a read-first RAM.
  always_comb begin
    if (zb_we_q && (zb_waddr_q == s1_addr_q)) begin
      stored_depth = zb_wdata_q;
    end else if (prev_we_q && (prev_addr_q == s1_addr_q)) begin
      stored_depth = prev_wdata_q;
    end else begin
      stored_depth = i_zb_rdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b1;
    s1_valid_d   = accept;
    s1_addr_d    = i_frag_addr;
    s1_depth_d   = i_frag_depth;
    s1_color_d   = i_frag_color;
    wr_valid_d   = s1_valid_q;
    zb_we_d      = s1_valid_q && (s1_depth_q < stored_depth);
    zb_waddr_d   = s1_addr_q;
    zb_wdata_d   = s1_depth_q;
    fb_wdata_d   = s1_color_q;
    prev_we_d    = zb_we_q;
    prev_addr_d  = zb_waddr_q;
    prev_wdata_d = zb_wdata_q;
    clr_cnt_d    = clr_cnt_q;
    case (state_q)
      IDLE: begin
        clr_cnt_d = '0;
        if (i_clear) begin
          state_d = (accept || s1_valid_q || wr_valid_q) ? DRAIN : CLEAR;
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !wr_valid_q) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        zb_we_d    = 1'b1;
        zb_waddr_d = clr_cnt_q[ADDRWIDTH-1:0];
        zb_wdata_d = '1;
        fb_wdata_d = CLEAR_COLOR;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_depth_q   <= '0;
      s1_color_q   <= '0;
      wr_valid_q   <= 1'b0;
      zb_we_q      <= 1'b0;
      zb_waddr_q   <= '0;
      zb_wdata_q   <= '0;
      fb_wdata_q   <= '0;
      prev_we_q    <= 1'b0;
      prev_addr_q  <= '0;
      prev_wdata_q <= '0;
      clr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_depth_q   <= s1_depth_d;
      s1_color_q   <= s1_color_d;
      wr_valid_q   <= wr_valid_d;
      zb_we_q      <= zb_we_d;
      zb_waddr_q   <= zb_waddr_d;
      zb_wdata_q   <= zb_wdata_d;
      fb_wdata_q   <= fb_wdata_d;
      prev_we_q    <= prev_we_d;
      prev_addr_q  <= prev_addr_d;
      prev_wdata_q <= prev_wdata_d;
      clr_cnt_q    <= clr_cnt_d;
    end
  end

endmodule

// File: tb/tb_depth_test_writer.sv
// tb/tb_depth_test_writer.sv - scoreboard bench for depth_test_writer
// Reference z-buffer array predicts every RAM write; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_depth_test_writer;
  localparam int DW = 12;
  localparam int CLW = 4;
  localparam int AW = 10;
  localparam int FB = 1024;
  localparam logic [CLW-1:0] CC = 4'hA;
  localparam logic [DW-1:0] FAR = '1;

  logic clk = 1'b0;
  logic rstn;
  logic i_frag_valid, i_clear;
  logic [AW-1:0] i_frag_addr;
  logic [DW-1:0] i_frag_depth;
  logic [CLW-1:0] i_frag_color;
  logic o_ready, o_clear_done, o_zb_we, o_fb_we;
  logic [AW-1:0] o_zb_raddr, o_zb_waddr, o_fb_waddr;
  logic [DW-1:0] i_zb_rdata, o_zb_wdata;
  logic [CLW-1:0] o_fb_wdata;

  always #5 clk = ~clk;

  depth_test_writer #(
    .DATAWIDTH(DW), .COLORWIDTH(CLW), .ADDRWIDTH(AW), .FB_SIZE(FB), .CLEAR_COLOR(CC)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_frag_valid(i_frag_valid), .i_frag_addr(i_frag_addr),
    .i_frag_depth(i_frag_depth), .i_frag_color(i_frag_color),
    .o_ready(o_ready), .i_clear(i_clear), .o_clear_done(o_clear_done),
    .o_zb_raddr(o_zb_raddr), .i_zb_rdata(i_zb_rdata),
    .o_zb_waddr(o_zb_waddr), .o_zb_wdata(o_zb_wdata), .o_zb_we(o_zb_we),
    .o_fb_waddr(o_fb_waddr), .o_fb_wdata(o_fb_wdata), .o_fb_we(o_fb_we)
  );

  // Read-first RAMs with one cycle of read latency.
  logic [DW-1:0]  zram [FB];
  logic [CLW-1:0] fram [FB];
  always @(posedge clk) begin
    i_zb_rdata <= zram[o_zb_raddr];
    if (o_zb_we) zram[o_zb_waddr] <= o_zb_wdata;
    if (o_fb_we) fram[o_fb_waddr] <= o_fb_wdata;
  end

  typedef struct {
    logic [AW-1:0]  a;
    logic [DW-1:0]  z;
    logic [CLW-1:0] c;
  } wr_t;

  wr_t sb[$];
  logic [DW-1:0]  ref_z [FB];
  logic [CLW-1:0] ref_c [FB];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic frag_issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CLW-1:0] c);
    if (d < ref_z[a]) begin
      ref_z[a] = d;
      ref_c[a] = c;
      sb.push_back('{a: a, z: d, c: c});
    end
  endtask

  task automatic clear_issue();
    for (int i = 0; i < FB; i++) begin
      ref_z[i] = FAR;
      ref_c[i] = CC;
      sb.push_back('{a: AW'(i), z: FAR, c: CC});
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 2 * FB) begin
      @(negedge clk);
      n++;
    end
    if (o_ready !== 1'b1) chk("wait_ready_timeout", {31'b0, o_ready}, 32'd1);
  endtask

  task automatic drive_frag(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CLW-1:0] c);
    wait_ready();
    i_frag_valid = 1'b1;
    i_frag_addr  = a;
    i_frag_depth = d;
    i_frag_color = c;
    frag_issue(a, d, c);
    @(negedge clk);
    i_frag_valid = 1'b0;
  endtask

  task automatic do_clear();
    wait_ready();
    i_clear = 1'b1;
    clear_issue();
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt);
    int n = 0;
    while (done_cnt < exp_cnt && n < FB + 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("clear_done_seen", done_cnt, exp_cnt);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, o_clear_done}, 32'd0);
    chk("ready_after_done", {31'b0, o_ready}, 32'd1);
  endtask

  // Monitor: every write on the RAM ports must match the oldest prediction.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (o_zb_we || o_fb_we) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0d depth 0x%0h colour 0x%0h, none expected",
                   o_zb_waddr, o_zb_wdata, o_fb_wdata);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (!(o_zb_we && o_fb_we && o_zb_waddr == e.a && o_fb_waddr == e.a &&
                o_zb_wdata == e.z && o_fb_wdata == e.c)) begin
            errors++;
            $display("FAIL write: got we %b/%b addr %0d/%0d depth 0x%0h colour 0x%0h expected addr %0d depth 0x%0h colour 0x%0h",
                     o_zb_we, o_fb_we, o_zb_waddr, o_fb_waddr, o_zb_wdata, o_fb_wdata, e.a, e.z, e.c);
          end
        end
      end
      if (o_clear_done) begin
        done_cnt++;
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL done_early: %0d writes outstanding, expected 0", sb.size());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int n;
    rstn = 1'b0;
    i_frag_valid = 1'b0;
    i_clear = 1'b0;
    i_frag_addr = '0;
    i_frag_depth = '0;
    i_frag_color = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, o_ready}, 32'd0);
    chk("rst_we", {30'b0, o_zb_we, o_fb_we}, 32'd0);
    chk("rst_data", {o_zb_waddr, o_zb_wdata, o_fb_wdata, o_clear_done}, 32'd0);
    chk("rst_fb_addr", {22'b0, o_fb_waddr}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, o_ready}, 32'd1);

    do_clear();
    wait_done(1);

    // Basic pass on a cleared buffer, with explicit two-cycle latency.
    drive_frag(10'd5, 12'd100, 4'd3);
    chk("lat1_no_write", {31'b0, o_zb_we}, 32'd0);
    @(negedge clk);
    chk("lat2_we", {30'b0, o_zb_we, o_fb_we}, 32'd3);
    chk("lat2_addr", {22'b0, o_zb_waddr}, 32'd5);
    chk("lat2_data", {16'b0, o_zb_wdata, o_fb_wdata}, {16'b0, 12'd100, 4'd3});

    // Equal depth fails, closer depth passes (back-to-back to one address).
    drive_frag(10'd7, 12'd50, 4'd1);
    drive_frag(10'd7, 12'd50, 4'd2);
    drive_frag(10'd7, 12'd49, 4'd4);
    repeat (4) @(negedge clk);
    drive_frag(10'd9, 12'd200, 4'd1);
    drive_frag(10'd9, 12'd150, 4'd2);
    drive_frag(10'd9, 12'd180, 4'd3);
    @(negedge clk);
    drive_frag(10'd9, 12'd160, 4'd4);
    drive_frag(10'd9, 12'd149, 4'd5);
    repeat (4) @(negedge clk);
    chk("directed_drained", sb.size(), 32'd0);

    // Clear requested with two fragments in flight.
    drive_frag(10'd20, 12'd10, 4'd5);
    drive_frag(10'd21, 12'd11, 4'd6);
    do_clear();
    chk("drain_ready_low", {31'b0, o_ready}, 32'd0);
    repeat (10) @(negedge clk);
    chk("clear_ready_low", {31'b0, o_ready}, 32'd0);
    wait_done(2);

    // Reset in the middle of a clear sweep.
    do_clear();
    n = 0;
    while (!(o_zb_we && o_zb_waddr == 10'd1000) && n < 2 * FB) begin
      @(negedge clk);
      n++;
    end
    chk("reached_addr_1000", {22'b0, o_zb_waddr}, 32'd1000);
    #2 rstn = 1'b0;
    #1;
    chk("midclr_rst_we", {29'b0, o_zb_we, o_fb_we, o_clear_done}, 32'd0);
    chk("midclr_rst_data", {o_zb_waddr, o_zb_wdata, o_fb_wdata, o_ready}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midclr_ready", {31'b0, o_ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("midclr_no_done", done_cnt, 32'd2);
    chk("midclr_no_writes", sb.size(), 32'd0);
    do_clear();
    wait_done(3);

    // Random stream with address clustering to exercise forwarding.
    sent = 0;
    while (sent < 10000) begin
      if ($urandom_range(0, 9) < 7) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [CLW-1:0] c;
        a = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, FB - 1));
        d = DW'($urandom);
        c = CLW'($urandom);
        drive_frag(a, d, c);
        sent++;
      end else begin
        @(negedge clk);
      end
    end
    repeat (5) @(negedge clk);
    chk("random_drained", sb.size(), 32'd0);
    for (int i = 0; i < FB; i++) begin
      chk("final_zram", {20'b0, zram[i]}, {20'b0, ref_z[i]});
      chk("final_fram", {28'b0, fram[i]}, {28'b0, ref_c[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
